// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle datapath: fetch, decode and per-class
// execute states with ARM-style conditional execution and Moore-style outputs.
module multicycle_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] INSTRUCTION,
  input  logic [3:0]  FLAGS,
  output logic        A3Src,
  output logic        AdrSrc,
  output logic        FlagUpdate,
  output logic        IRWrite,
  output logic        MemWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        WD3Src,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  RegSrc,
  output logic [2:0]  ALUop,
  output logic [2:0]  ShiftType,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  state_t state_q, state_d;
  logic   run_q, run_d;

  logic [3:0] cond, cmd;
  logic [1:0] op, sh;
  logic       i_bit, s_bit, link;
  logic       cond_pass, is_cmp;
  logic [2:0] alu_dec;
  logic       n_f, z_f, c_f, v_f;
  logic       irw, pcw, rw, mw, fu;
  logic       unused_instr;

  assign cond  = INSTRUCTION[31:28];
  assign op    = INSTRUCTION[27:26];
  assign i_bit = INSTRUCTION[25];
  assign cmd   = INSTRUCTION[24:21];
  assign link  = INSTRUCTION[24];
  assign s_bit = INSTRUCTION[20];
  assign sh    = INSTRUCTION[6:5];
  assign {n_f, z_f, c_f, v_f} = FLAGS;
  assign unused_instr = ^{INSTRUCTION[19:7], INSTRUCTION[4:0]};

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'h0: cond_pass = z_f;
      4'h1: cond_pass = !z_f;
      4'h2: cond_pass = c_f;
      4'h3: cond_pass = !c_f;
      4'h4: cond_pass = n_f;
      4'h5: cond_pass = !n_f;
      4'h6: cond_pass = v_f;
      4'h7: cond_pass = !v_f;
      4'h8: cond_pass = c_f && !z_f;
      4'h9: cond_pass = !c_f || z_f;
      4'hA: cond_pass = (n_f == v_f);
      4'hB: cond_pass = (n_f != v_f);
      4'hC: cond_pass = !z_f && (n_f == v_f);
      4'hD: cond_pass = z_f || (n_f != v_f);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  always_comb begin
    is_cmp  = (cmd == 4'b1010);
    alu_dec = 3'b000;
    case (cmd)
      4'b0010, 4'b1010: alu_dec = 3'b001;
      4'b0000:          alu_dec = 3'b010;
      4'b1100:          alu_dec = 3'b011;
      4'b1101:          alu_dec = 3'b100;
      default:          alu_dec = 3'b000;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    run_d     = 1'b1;
    A3Src     = 1'b0;
    AdrSrc    = 1'b0;
    fu        = 1'b0;
    irw       = 1'b0;
    mw        = 1'b0;
    pcw       = 1'b0;
    rw        = 1'b0;
    WD3Src    = 1'b0;
    ALUSrcA   = '0;
    ALUSrcB   = '0;
    ResultSrc = '0;
    RegSrc    = 2'b10;
    ALUop     = '0;
    ShiftType = '1;
    case (state_q)
      S_FETCH: begin
        irw = 1'b1; pcw = 1'b1;
        ALUSrcB = 2'b11; ResultSrc = 2'b10;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11; ResultSrc = 2'b10;
        RegSrc  = {(op == 2'b01) && !s_bit, (op == 2'b10)};
        if (!cond_pass || op == 2'b11) state_d = S_FETCH;
        else if (op == 2'b01)          state_d = S_MEMADR;
        else if (op == 2'b00)          state_d = i_bit ? S_EXECI : S_EXECR;
        else                           state_d = S_BRANCH;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b01;
        state_d = s_bit ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        rw = 1'b1; ResultSrc = 2'b01;
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1; mw = 1'b1;
        state_d = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcA = 2'b01;
        ALUSrcB = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        ALUop   = alu_dec;
        fu      = s_bit || is_cmp;
        if (state_q == S_EXECR) ShiftType = {1'b0, sh};
        state_d = is_cmp ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        rw = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b01; ResultSrc = 2'b10;
        pcw = 1'b1;
        rw = link; A3Src = link; WD3Src = link;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // Hold in FETCH for the first edge after reset release so strobes start one cycle later.
    if (!run_q) state_d = S_FETCH;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  // run_q is cleared asynchronously, so write strobes cannot glitch during reset.
  assign IRWrite    = irw & run_q;
  assign PCWrite    = pcw & run_q;
  assign RegWrite   = rw  & run_q;
  assign MemWrite   = mw  & run_q;
  assign FlagUpdate = fu  & run_q;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed vector table, reset
// corner sequences and random instructions against a per-class cycle-plan model.
module tb_multicycle_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] INSTRUCTION;
  logic [3:0]  FLAGS;
  logic        A3Src, AdrSrc, FlagUpdate, IRWrite, MemWrite, PCWrite, RegWrite, WD3Src;
  logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc, RegSrc;
  logic [2:0]  ALUop, ShiftType;
  logic [3:0]  state;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [21:0] plan [5];
  int          plan_n;

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  flags;
    int          cycles;
  } vec_t;
  vec_t tbl [14];

  multicycle_controller dut (
    .clock(clock), .reset(reset), .INSTRUCTION(INSTRUCTION), .FLAGS(FLAGS),
    .A3Src(A3Src), .AdrSrc(AdrSrc), .FlagUpdate(FlagUpdate), .IRWrite(IRWrite),
    .MemWrite(MemWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .WD3Src(WD3Src),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .RegSrc(RegSrc),
    .ALUop(ALUop), .ShiftType(ShiftType), .state(state)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1);
  end

  function automatic logic [21:0] mk(input logic a3, adr, fu, irw, mw, pcw, rw, wd3,
                                     input logic [1:0] sa, sb, rs, rg,
                                     input logic [2:0] aop, sht);
    return {a3, adr, fu, irw, mw, pcw, rw, wd3, sa, sb, rs, rg, aop, sht};
  endfunction

  function automatic logic [21:0] dut_out();
    return {A3Src, AdrSrc, FlagUpdate, IRWrite, MemWrite, PCWrite, RegWrite, WD3Src,
            ALUSrcA, ALUSrcB, ResultSrc, RegSrc, ALUop, ShiftType};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0: return z;         4'h1: return !z;
      4'h2: return cf;        4'h3: return !cf;
      4'h4: return n;         4'h5: return !n;
      4'h6: return v;         4'h7: return !v;
      4'h8: return cf && !z;  4'h9: return !cf || z;
      4'hA: return n == v;    4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Expected per-cycle outputs of one instruction, FETCH first.
  task automatic build_plan(input logic [31:0] ins, input logic [3:0] f);
    logic [1:0] op;
    logic       l, i, lk, s, cmp;
    logic [3:0] cmd;
    logic [2:0] aop;
    op = ins[27:26]; l = ins[20]; i = ins[25]; cmd = ins[24:21]; lk = ins[24]; s = ins[20];
    plan[0] = mk(0,0,0,1,0,1,0,0, 2'b00, 2'b11, 2'b10, 2'b10, 3'b000, 3'b111);
    plan[1] = mk(0,0,0,0,0,0,0,0, 2'b00, 2'b11, 2'b10, {op == 2'd1 && !l, op == 2'd2}, 3'b000, 3'b111);
    if (!cond_ok(ins[31:28], f) || op == 2'd3) begin
      plan_n = 2;
    end else if (op == 2'd1) begin
      plan[2] = mk(0,0,0,0,0,0,0,0, 2'b01, 2'b01, 2'b00, 2'b10, 3'b000, 3'b111);
      if (l) begin
        plan[3] = mk(0,1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b10, 3'b000, 3'b111);
        plan[4] = mk(0,0,0,0,0,0,1,0, 2'b00, 2'b00, 2'b01, 2'b10, 3'b000, 3'b111);
        plan_n = 5;
      end else begin
        plan[3] = mk(0,1,0,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b10, 3'b000, 3'b111);
        plan_n = 4;
      end
    end else if (op == 2'd0) begin
      cmp = (cmd == 4'b1010);
      case (cmd)
        4'b0010, 4'b1010: aop = 3'd1;
        4'b0000: aop = 3'd2;
        4'b1100: aop = 3'd3;
        4'b1101: aop = 3'd4;
        default: aop = 3'd0;
      endcase
      plan[2] = mk(0,0,s | cmp,0,0,0,0,0, 2'b01, {1'b0, i}, 2'b00, 2'b10, aop,
                   i ? 3'b111 : {1'b0, ins[6:5]});
      if (cmp) plan_n = 3;
      else begin
        plan[3] = mk(0,0,0,0,0,0,1,0, 2'b00, 2'b00, 2'b00, 2'b10, 3'b000, 3'b111);
        plan_n = 4;
      end
    end else begin
      plan[2] = mk(lk,0,0,0,0,1,lk,lk, 2'b01, 2'b01, 2'b10, 2'b10, 3'b000, 3'b111);
      plan_n = 3;
    end
  endtask

  // Entered just after a rising edge with the DUT in FETCH; leaves it the same way.
  task automatic run_instr(input logic [31:0] ins, input logic [3:0] fdec, input int cycles);
    int n;
    build_plan(ins, fdec);
    n = (cycles > 0) ? cycles : plan_n;
    INSTRUCTION = ins;
    for (int c = 0; c < n; c++) begin
      FLAGS = (c == 1) ? fdec : 4'($urandom);
      @(negedge clock);
      if (c < plan_n)
        check($sformatf("%08h cyc%0d outputs", ins, c), 32'(dut_out()), 32'(plan[c]));
      if (c == 0) check($sformatf("%08h fetch state", ins), 32'(state), 32'd0);
      else        check($sformatf("%08h busy state", ins), 32'(state != 4'd0), 32'd1);
      @(posedge clock); #1;
    end
  endtask

  initial begin
    logic [21:0] fetch_gated;
    logic [31:0] ins;
    fetch_gated = mk(0,0,0,0,0,0,0,0, 2'b00, 2'b11, 2'b10, 2'b10, 3'b000, 3'b111);

    tbl[0]  = '{32'hE5901004, 4'b0000, 5};  // LDR
    tbl[1]  = '{32'hE5801004, 4'b0000, 4};  // STR
    tbl[2]  = '{32'hE0912003, 4'b0000, 4};  // ADDS reg
    tbl[3]  = '{32'hE1510002, 4'b0000, 3};  // CMP
    tbl[4]  = '{32'h0A000002, 4'b0100, 3};  // BEQ taken
    tbl[5]  = '{32'h0A000002, 4'b0000, 2};  // BEQ not taken
    tbl[6]  = '{32'hEB000001, 4'b0000, 3};  // BL
    tbl[7]  = '{32'hEC000000, 4'b0000, 2};  // op 11
    tbl[8]  = '{32'hF0912003, 4'b1111, 2};  // never
    tbl[9]  = '{32'hE3A01005, 4'b0000, 4};  // MOV imm
    tbl[10] = '{32'hE1812043, 4'b0000, 4};  // ORR reg, sh=10
    tbl[11] = '{32'hC0912003, 4'b0000, 4};  // GT pass
    tbl[12] = '{32'hC0912003, 4'b0100, 2};  // GT fail
    tbl[13] = '{32'hB2412001, 4'b1000, 4};  // SUBLT imm

    reset = 1'b0;
    INSTRUCTION = 32'hE5901004;
    FLAGS = 4'b0000;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset state", 32'(state), 32'd0);
    check("reset PCWrite", 32'(PCWrite), 32'd0);
    check("reset IRWrite", 32'(IRWrite), 32'd0);
    check("reset outputs", 32'(dut_out()), 32'(fetch_gated));
    reset = 1'b1;
    #1;
    check("release pre-edge strobes", 32'(dut_out()), 32'(fetch_gated));
    @(posedge clock); #1;

    foreach (tbl[k]) run_instr(tbl[k].ins, tbl[k].flags, tbl[k].cycles);

    for (int r = 0; r < 250; r++) begin
      ins = $urandom;
      if ($urandom_range(0, 1) == 1) ins[31:28] = 4'hE;
      run_instr(ins, 4'($urandom), 0);
    end

    INSTRUCTION = 32'hEB000001;
    FLAGS = 4'b0000;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("BL branch outputs", 32'(dut_out()),
          32'(mk(1,0,0,0,0,1,1,1, 2'b01, 2'b01, 2'b10, 2'b10, 3'b000, 3'b111)));
    reset = 1'b0;
    #1;
    check("abort outputs", 32'(dut_out()), 32'(fetch_gated));
    check("abort state", 32'(state), 32'd0);
    @(negedge clock);
    check("abort hold outputs", 32'(dut_out()), 32'(fetch_gated));
    reset = 1'b1;
    #1;
    check("abort release strobes", 32'(dut_out()), 32'(fetch_gated));
    @(posedge clock); #1;
    run_instr(32'hE5901004, 4'b0000, 5);
    @(negedge clock);
    check("final fetch state", 32'(state), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
